ram_stream_reader: RTL and testbench

- Read-side controller for the simple dual-port RAM blocks (1-cycle registered read, read_en gated).
- On a start command it walks a contiguous address range, issues RAM reads, and presents the returned words as a valid/ready stream with a last-word marker.
- Sits between a weight/activation RAM and the downstream compute pipeline.
- Absorbs downstream backpressure with a small output FIFO, so no RAM data is ever dropped.

---
 rtl/ram_stream_reader_if.sv | 46 ++++
 rtl/ram_stream_reader.sv | 184 ++++++++++++++++++
 tb/tb_ram_stream_reader.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_stream_reader_if.sv
`default_nettype none
// ============================================================================
//  Module      : ram_stream_reader_if
//  Description : Bundles the RAM read port and the outgoing valid/ready
//                stream of ram_stream_reader.
//                master : reader side (drives RAM read, drives stream)
//                slave  : RAM + downstream side
//  Ports       : ram_read_en, ram_read_address -> RAM
//                ram_read_data                 <- RAM (1-cycle registered)
//                m_valid, m_data, m_last       -> downstream
//                m_ready                       <- downstream
//  Revision    : 1.0  initial release
// ============================================================================
interface ram_stream_reader_if #(
    parameter int WIDTH      = 72,
    parameter int DEPTH_BITS = 10
);
    logic                  ram_read_en;
    logic [DEPTH_BITS-1:0] ram_read_address;
    logic [WIDTH-1:0]      ram_read_data;
    logic                  m_valid;
    logic [WIDTH-1:0]      m_data;
    logic                  m_last;
    logic                  m_ready;

    modport master (
        output ram_read_en,
        output ram_read_address,
        input  ram_read_data,
        output m_valid,
        output m_data,
        output m_last,
        input  m_ready
    );

    modport slave (
        input  ram_read_en,
        input  ram_read_address,
        output ram_read_data,
        input  m_valid,
        input  m_data,
        input  m_last,
        output m_ready
    );
endinterface
`default_nettype wire

// File: rtl/ram_stream_reader.sv
`default_nettype none
// ============================================================================
//  Module      : ram_stream_reader
//  Description : Walks a contiguous RAM address range after a start command,
//                issues 1-cycle-latency reads and streams the returned words
//                out over valid/ready with a last-word marker. A 4-entry
//                output FIFO plus a credit rule absorbs backpressure so no
//                returned RAM word is ever dropped.
//  Ports       : clk, rst_n (async, active low)
//                start, base_addr, length  - transfer command
//                busy, done                - transfer status
//                bus (master modport)      - RAM read port + output stream
//  Revision    : 1.0  initial release
// ============================================================================
module ram_stream_reader #(
    parameter int WIDTH      = 72,
    parameter int DEPTH_BITS = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    input  wire logic                  start,
    input  wire logic [DEPTH_BITS-1:0] base_addr,
    input  wire logic [DEPTH_BITS:0]   length,
    output logic                       busy,
    output logic                       done,
    ram_stream_reader_if.master        bus
);

    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = $clog2(FIFO_DEPTH + 1);

    // Issue allowed while FIFO occupancy plus the in-flight read is at most 2,
    // which bounds occupancy at 3 even with the consumer fully stalled.
    localparam logic [c_CNT_W:0]     c_CREDIT_LIMIT = 2;
    localparam logic [c_CNT_W-1:0]   c_MAX_OCC      = c_CNT_W'(FIFO_DEPTH - 1);
    localparam logic [DEPTH_BITS:0]  c_ONE_LEFT     = 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [DEPTH_BITS-1:0]  r_addr;
    logic [DEPTH_BITS:0]    r_remaining;
    logic                   r_pending;
    logic                   r_pending_last;

    logic [WIDTH-1:0]       r_fifo_data [FIFO_DEPTH];
    logic                   r_fifo_last [FIFO_DEPTH];
    logic [c_PTR_W-1:0]     r_wr_ptr;
    logic [c_PTR_W-1:0]     r_rd_ptr;
    logic [c_CNT_W-1:0]     r_count;

    logic                   w_issue;
    logic                   w_done;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_fifo_empty;
    logic                   w_credit_ok;
    logic                   w_accept;

    assign w_fifo_empty = (r_count == '0);
    assign w_credit_ok  = (({1'b0, r_count} + {{c_CNT_W{1'b0}}, r_pending}) <= c_CREDIT_LIMIT);
    assign w_accept     = (r_state == S_IDLE) && start;
    // Read data is valid in the cycle after the issue; it lands in the FIFO
    // at the end of that cycle.
    assign w_push       = r_pending;
    assign w_pop        = bus.m_valid && bus.m_ready;

    // ------------------------------------------------------------------
    // FSM next state / strobes
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = (length == '0) ? S_DRAIN : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (w_credit_ok) begin
                    w_issue = 1'b1;
                    if (r_remaining == c_ONE_LEFT) begin
                        w_state_nxt = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (w_fifo_empty && !r_pending) begin
                    w_done      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Address walker and in-flight read tracking
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr         <= '0;
            r_remaining    <= '0;
            r_pending      <= 1'b0;
            r_pending_last <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr      <= base_addr;
                r_remaining <= length;
            end else if (w_issue) begin
                // Natural wrap of the address register gives the modulo walk.
                r_addr      <= r_addr + 1'b1;
                r_remaining <= r_remaining - 1'b1;
            end
            r_pending      <= w_issue;
            r_pending_last <= w_issue && (r_remaining == c_ONE_LEFT);
        end
    end

    // ------------------------------------------------------------------
    // Output FIFO: control state is reset, storage is not
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_data[r_wr_ptr] <= bus.ram_read_data;
            r_fifo_last[r_wr_ptr] <= r_pending_last;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.ram_read_en      = w_issue;
    assign bus.ram_read_address = r_addr;
    assign bus.m_valid          = !w_fifo_empty;
    assign bus.m_data           = r_fifo_data[r_rd_ptr];
    // Gated so m_last reads 0 while no word is presented (incl. reset).
    assign bus.m_last           = !w_fifo_empty && r_fifo_last[r_rd_ptr];
    assign busy                 = (r_state != S_IDLE);
    assign done                 = w_done;

    // The credit rule must keep the FIFO from ever filling past 3 entries.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) r_count <= c_MAX_OCC);

endmodule
`default_nettype wire

// File: tb/tb_ram_stream_reader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_ram_stream_reader
//  Description : Self-checking bench for ram_stream_reader. A behavioural RAM
//                and an expected-word queue built from address arithmetic
//                model each transfer; a table of transfers is run in a loop,
//                followed by a mid-transfer reset sequence.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ram_stream_reader;

    localparam int WIDTH      = 72;
    localparam int DEPTH_BITS = 10;
    localparam int NWORDS     = 1 << DEPTH_BITS;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  start = 1'b0;
    logic [DEPTH_BITS-1:0] base_addr = '0;
    logic [DEPTH_BITS:0]   length = '0;
    logic                  busy;
    logic                  done;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [WIDTH-1:0] mem [NWORDS];

    ram_stream_reader_if #(.WIDTH(WIDTH), .DEPTH_BITS(DEPTH_BITS)) bus ();

    ram_stream_reader #(
        .WIDTH      (WIDTH),
        .DEPTH_BITS (DEPTH_BITS),
        .FIFO_DEPTH (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .busy      (busy),
        .done      (done),
        .bus       (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural RAM: registered read, updated only when read_en is high.
    always @(posedge clk) begin
        if (bus.ram_read_en) bus.ram_read_data <= mem[bus.ram_read_address];
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [WIDTH-1:0] rand_word();
        logic [95:0] t;
        t = {$urandom(), $urandom(), $urandom()};
        return t[WIDTH-1:0];
    endfunction

    function automatic logic ready_for(input int mode, input int k);
        case (mode)
            0:       return 1'b1;
            1:       return (k >= 11);
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    typedef struct packed {
        logic [WIDTH-1:0] d;
        logic             l;
    } beat_t;

    // Runs one transfer. Cycle 0 is the cycle with start=1.
    task automatic run_xfer(input logic [DEPTH_BITS-1:0] b, input int len, input int mode,
                            input int restart_at, input int exp_done);
        beat_t                 expq[$];
        beat_t                 e;
        logic [DEPTH_BITS-1:0] a;
        logic [WIDTH-1:0]      prev_d;
        logic                  prev_l;
        logic                  prev_stall;
        bit                    finished;
        int issued, popped, done_cyc, first_valid, first_issue, ren_early, max_occ, last_hs;

        for (int i = 0; i < len; i++) begin
            a = b + DEPTH_BITS'(i);
            e.d = mem[a];
            e.l = (i == len - 1);
            expq.push_back(e);
        end
        issued = 0; popped = 0; done_cyc = -1; first_valid = -1; first_issue = -1;
        ren_early = 0; max_occ = 0; last_hs = -1; prev_stall = 1'b0; finished = 1'b0;
        prev_d = '0; prev_l = 1'b0;

        @(posedge clk); #1;
        start       = 1'b1;
        base_addr   = b;
        length      = (DEPTH_BITS+1)'(len);
        bus.m_ready = ready_for(mode, 0);
        @(negedge clk);
        chk("idle_before_start_busy", busy, 1'b0);

        for (int k = 1; k <= 400 && !finished; k++) begin
            @(posedge clk); #1;
            start = (k == restart_at);
            if (k == restart_at) begin
                base_addr = b ^ 10'h155;
                length    = (DEPTH_BITS+1)'(len + 5);
            end
            bus.m_ready = ready_for(mode, k);
            @(negedge clk);
            if (issued - popped > max_occ) max_occ = issued - popped;
            if (bus.ram_read_en) begin
                a = b + DEPTH_BITS'(issued);
                chk("read_address", bus.ram_read_address, a);
                if (first_issue < 0) first_issue = k;
                if (k < 11) ren_early++;
                issued++;
            end
            if (bus.m_valid) begin
                if (first_valid < 0) first_valid = k;
                if (prev_stall) begin
                    chk("stall_data_stable", bus.m_data, prev_d);
                    chk("stall_last_stable", bus.m_last, prev_l);
                end
            end
            prev_stall = bus.m_valid && !bus.m_ready;
            prev_d     = bus.m_data;
            prev_l     = bus.m_last;
            if (bus.m_valid && bus.m_ready) begin
                if (expq.size() == 0) begin
                    chk("extra_word", 1'b1, 1'b0);
                end else begin
                    e = expq.pop_front();
                    chk("m_data", bus.m_data, e.d);
                    chk("m_last", bus.m_last, e.l);
                end
                popped++;
                last_hs = k;
            end
            if (done) begin
                done_cyc = k;
                chk("busy_during_done", busy, 1'b1);
                finished = 1'b1;
            end
        end
        if (!finished) chk("done_timeout", 1'b0, 1'b1);

        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("done_single_pulse", done, 1'b0);
        chk("busy_after_done", busy, 1'b0);

        chk("issue_count", 128'(issued), 128'(len));
        chk("word_count", 128'(popped), 128'(len));
        chk("words_left_unsent", 128'(expq.size()), 128'(0));
        chk("occupancy_le_3", 128'(max_occ <= 3), 128'(1));
        chk("first_issue_cycle", 128'(first_issue), 128'(len > 0 ? 1 : -1));
        chk("first_valid_cycle", 128'(first_valid), 128'(len > 0 ? 3 : -1));
        chk("done_after_last_word", 128'(done_cyc), 128'(len == 0 ? 1 : last_hs + 1));
        if (exp_done >= 0) chk("done_cycle", 128'(done_cyc), 128'(exp_done));
        if (mode == 1 && len >= 3) chk("issues_while_stalled", 128'(ren_early), 128'(3));
    endtask

    typedef struct {
        logic [DEPTH_BITS-1:0] base;
        int                    len;
        int                    mode;       // 0: ready=1, 1: stall until cycle 11, 2: random
        int                    restart_at; // cycle of an ignored start, -1 for none
        int                    exp_done;   // -1 when not fixed by the pattern
    } vec_t;

    vec_t vecs[9];

    initial begin
        int rl;
        logic [DEPTH_BITS-1:0] rb;

        for (int i = 0; i < NWORDS; i++) mem[i] = rand_word();
        mem[10'h010] = 72'hAA_0000_0000_0000_000A;
        mem[10'h011] = 72'hBB_0000_0000_0000_000B;
        mem[10'h012] = 72'hCC_0000_0000_0000_000C;
        mem[10'h013] = 72'hDD_0000_0000_0000_000D;
        bus.m_ready = 1'b0;

        vecs[0] = '{10'h010, 4, 0, -1, 7};
        vecs[1] = '{10'h010, 4, 1, -1, -1};
        vecs[2] = '{10'h3FE, 4, 0, -1, 7};
        vecs[3] = '{10'h000, 0, 0, -1, 1};
        vecs[4] = '{10'h010, 4, 0, 2, 7};
        vecs[5] = '{10'h3FF, 1, 0, -1, 4};
        rb = DEPTH_BITS'($urandom());
        vecs[6] = '{rb, 64, 2, -1, -1};
        rb = DEPTH_BITS'($urandom());
        rl = int'($urandom_range(1, 16));
        vecs[7] = '{rb, rl, 2, 5, -1};
        rb = DEPTH_BITS'($urandom());
        rl = int'($urandom_range(1, 16));
        vecs[8] = '{rb, rl, 0, -1, rl + 3};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_read_en", bus.ram_read_en, 1'b0);
        chk("reset_address", bus.ram_read_address, 10'h000);
        chk("reset_m_valid", bus.m_valid, 1'b0);
        chk("reset_m_last", bus.m_last, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            run_xfer(vecs[i].base, vecs[i].len, vecs[i].mode, vecs[i].restart_at, vecs[i].exp_done);
        end

        // Asynchronous reset in cycle 4 of a length-8 transfer
        @(posedge clk); #1;
        start       = 1'b1;
        base_addr   = 10'h100;
        length      = 11'd8;
        bus.m_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midreset_busy", busy, 1'b0);
        chk("midreset_done", done, 1'b0);
        chk("midreset_read_en", bus.ram_read_en, 1'b0);
        chk("midreset_address", bus.ram_read_address, 10'h000);
        chk("midreset_m_valid", bus.m_valid, 1'b0);
        chk("midreset_m_last", bus.m_last, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_xfer(10'h200, 2, 0, -1, 5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
